// File: rtl/cyclotron_trace_pkg.sv
// rtl/cyclotron_trace_pkg.sv - shared types and beat-width derivation for the trace packer
package cyclotron_trace_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SEQ     = 2'd1,
    ERR_HDR     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ERROR = 2'd2
  } state_e;

  // Beat index width; a single-beat configuration still gets a 1-bit field.
  function automatic int beat_bits(input int num_lanes, input int wb_lanes);
    int nb;
    nb = num_lanes / wb_lanes;
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/cyclotron_trace_lane_accum.sv
// rtl/cyclotron_trace_lane_accum.sv - three-register lane-slice accumulator indexed by beat
module cyclotron_trace_lane_accum
  import cyclotron_trace_pkg::*;
#(
  parameter int ARCH_LEN  = 32,
  parameter int NUM_LANES = 16,
  parameter int WB_LANES  = 4,
  parameter int BEAT_BITS = beat_bits(NUM_LANES, WB_LANES)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   wr_valid,
  input  logic [2:0]                             wr_en,
  input  logic [BEAT_BITS-1:0]                   wr_beat,
  input  logic [2:0][WB_LANES*ARCH_LEN-1:0]      wr_data,
  output logic [2:0][NUM_LANES*ARCH_LEN-1:0]     merged
);

  localparam int NUM_BEATS = NUM_LANES / WB_LANES;
  localparam int SLICE_W   = WB_LANES * ARCH_LEN;
  localparam int FULL_W    = NUM_LANES * ARCH_LEN;

  logic [2:0][FULL_W-1:0] acc;

  // merged shows the accumulator with this cycle's slice already applied, so the
  // final beat can be emitted on the same edge it is written.
  for (genvar k = 0; k < 3; k++) begin : g_reg
    for (genvar b = 0; b < NUM_BEATS; b++) begin : g_beat
      assign merged[k][b*SLICE_W +: SLICE_W] =
        (wr_valid && wr_en[k] && (wr_beat == BEAT_BITS'(b))) ? wr_data[k]
                                                            : acc[k][b*SLICE_W +: SLICE_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_valid && wr_en[k]) acc[k] <= merged[k];
      end
    end
  end

endmodule

// File: rtl/cyclotron_trace_packer.sv
// rtl/cyclotron_trace_packer.sv - reassembles writeback lane-group beats into full-warp trace records
module cyclotron_trace_packer
  import cyclotron_trace_pkg::*;
#(
  parameter int ARCH_LEN     = 32,
  parameter int NUM_WARPS    = 8,
  parameter int NUM_LANES    = 16,
  parameter int WB_LANES     = 4,
  parameter int REG_BITS     = 8,
  parameter int TIMEOUT      = 1024,
  parameter int WARP_ID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int BEAT_BITS    = beat_bits(NUM_LANES, WB_LANES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wb_valid,
  output logic                            wb_ready,
  input  logic [ARCH_LEN-1:0]             wb_pc,
  input  logic [WARP_ID_BITS-1:0]         wb_warpId,
  input  logic [NUM_LANES-1:0]            wb_tmask,
  input  logic [BEAT_BITS-1:0]            wb_beat,
  input  logic                            wb_last,
  input  logic                            wb_regs_0_enable,
  input  logic [REG_BITS-1:0]             wb_regs_0_address,
  input  logic [WB_LANES*ARCH_LEN-1:0]    wb_regs_0_data,
  input  logic                            wb_regs_1_enable,
  input  logic [REG_BITS-1:0]             wb_regs_1_address,
  input  logic [WB_LANES*ARCH_LEN-1:0]    wb_regs_1_data,
  input  logic                            wb_regs_2_enable,
  input  logic [REG_BITS-1:0]             wb_regs_2_address,
  input  logic [WB_LANES*ARCH_LEN-1:0]    wb_regs_2_data,
  output logic                            trace_valid,
  output logic [ARCH_LEN-1:0]             trace_pc,
  output logic [WARP_ID_BITS-1:0]         trace_warpId,
  output logic [NUM_LANES-1:0]            trace_tmask,
  output logic                            trace_regs_0_enable,
  output logic [REG_BITS-1:0]             trace_regs_0_address,
  output logic [NUM_LANES*ARCH_LEN-1:0]   trace_regs_0_data,
  output logic                            trace_regs_1_enable,
  output logic [REG_BITS-1:0]             trace_regs_1_address,
  output logic [NUM_LANES*ARCH_LEN-1:0]   trace_regs_1_data,
  output logic                            trace_regs_2_enable,
  output logic [REG_BITS-1:0]             trace_regs_2_address,
  output logic [NUM_LANES*ARCH_LEN-1:0]   trace_regs_2_data,
  output logic                            err_valid,
  output logic [1:0]                      err_code
);

  localparam int NUM_BEATS = NUM_LANES / WB_LANES;
  localparam int SLICE_W   = WB_LANES * ARCH_LEN;
  localparam int FULL_W    = NUM_LANES * ARCH_LEN;
  localparam int CNT_BITS  = $clog2(TIMEOUT + 1);

  state_e                        state, state_n;
  err_code_e                     err_n;
  logic                          accept, beat_ok, emit, is_final, last_bad, hdr_bad;
  logic [2:0]                    wb_en, hdr_en;
  logic [2:0][REG_BITS-1:0]      wb_addr, hdr_addr;
  logic [2:0][SLICE_W-1:0]       wb_data;
  logic [2:0][FULL_W-1:0]        merged;
  logic [ARCH_LEN-1:0]           hdr_pc;
  logic [WARP_ID_BITS-1:0]       hdr_warp;
  logic [NUM_LANES-1:0]          hdr_tmask;
  logic [BEAT_BITS-1:0]          exp_beat;
  logic [CNT_BITS-1:0]           tcnt;

  assign wb_en   = {wb_regs_2_enable, wb_regs_1_enable, wb_regs_0_enable};
  assign wb_addr = {wb_regs_2_address, wb_regs_1_address, wb_regs_0_address};
  assign wb_data = {wb_regs_2_data, wb_regs_1_data, wb_regs_0_data};

  assign accept   = wb_valid && wb_ready;
  assign is_final = (wb_beat == BEAT_BITS'(NUM_BEATS - 1));
  assign last_bad = (wb_last != is_final);
  assign hdr_bad  = (wb_pc != hdr_pc) || (wb_warpId != hdr_warp) || (wb_tmask != hdr_tmask) ||
                    (wb_en != hdr_en) || (wb_addr != hdr_addr);

  cyclotron_trace_lane_accum #(
    .ARCH_LEN (ARCH_LEN),
    .NUM_LANES(NUM_LANES),
    .WB_LANES (WB_LANES),
    .BEAT_BITS(BEAT_BITS)
  ) u_accum (
    .clock   (clock),
    .reset   (reset),
    .wr_valid(beat_ok),
    .wr_en   (wb_en),
    .wr_beat (wb_beat),
    .wr_data (wb_data),
    .merged  (merged)
  );

  // Sequence errors outrank header errors; an erroring beat never reaches the accumulator.
  always_comb begin
    state_n = state;
    err_n   = ERR_NONE;
    beat_ok = 1'b0;
    emit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((wb_beat != '0) || last_bad) begin
            err_n = ERR_SEQ;
          end else begin
            beat_ok = 1'b1;
            if (wb_last) emit = 1'b1;
            else         state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if ((wb_beat != exp_beat) || last_bad) begin
            err_n = ERR_SEQ;
          end else if (hdr_bad) begin
            err_n = ERR_HDR;
          end else begin
            beat_ok = 1'b1;
            if (wb_last) begin
              emit    = 1'b1;
              state_n = IDLE;
            end
          end
        end else if (tcnt == CNT_BITS'(TIMEOUT - 1)) begin
          err_n = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
    if (err_n != ERR_NONE) state_n = ERROR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      wb_ready             <= 1'b0;
      hdr_pc               <= '0;
      hdr_warp             <= '0;
      hdr_tmask            <= '0;
      hdr_en               <= '0;
      hdr_addr             <= '0;
      exp_beat             <= '0;
      tcnt                 <= '0;
      err_valid            <= 1'b0;
      err_code             <= '0;
      trace_valid          <= 1'b0;
      trace_pc             <= '0;
      trace_warpId         <= '0;
      trace_tmask          <= '0;
      trace_regs_0_enable  <= 1'b0;
      trace_regs_0_address <= '0;
      trace_regs_0_data    <= '0;
      trace_regs_1_enable  <= 1'b0;
      trace_regs_1_address <= '0;
      trace_regs_1_data    <= '0;
      trace_regs_2_enable  <= 1'b0;
      trace_regs_2_address <= '0;
      trace_regs_2_data    <= '0;
    end else begin
      state       <= state_n;
      wb_ready    <= (state_n != ERROR);
      trace_valid <= emit;
      if (beat_ok) begin
        hdr_pc    <= wb_pc;
        hdr_warp  <= wb_warpId;
        hdr_tmask <= wb_tmask;
        hdr_en    <= wb_en;
        hdr_addr  <= wb_addr;
        exp_beat  <= wb_beat + 1'b1;
      end
      if (accept)                                           tcnt <= '0;
      else if (state == ACCUM && tcnt != CNT_BITS'(TIMEOUT)) tcnt <= tcnt + 1'b1;
      if (err_n != ERR_NONE) begin
        err_valid <= 1'b1;
        err_code  <= err_n;
      end
      // Header fields come straight from the final beat: it was just proven equal to the latch.
      if (emit) begin
        trace_pc             <= wb_pc;
        trace_warpId         <= wb_warpId;
        trace_tmask          <= wb_tmask;
        trace_regs_0_enable  <= wb_en[0];
        trace_regs_0_address <= wb_addr[0];
        trace_regs_0_data    <= wb_en[0] ? merged[0] : '0;
        trace_regs_1_enable  <= wb_en[1];
        trace_regs_1_address <= wb_addr[1];
        trace_regs_1_data    <= wb_en[1] ? merged[1] : '0;
        trace_regs_2_enable  <= wb_en[2];
        trace_regs_2_address <= wb_addr[2];
        trace_regs_2_data    <= wb_en[2] ? merged[2] : '0;
      end
    end
  end

endmodule

// File: tb/tb_cyclotron_trace_packer.sv
// tb/tb_cyclotron_trace_packer.sv - randomized self-checking bench for cyclotron_trace_packer
module tb_cyclotron_trace_packer;

  typedef struct packed {
    logic [31:0]       pc;
    logic [2:0]        warp;
    logic [15:0]       tmask;
    logic [2:0]        en;
    logic [2:0][7:0]   addr;
    logic [2:0][511:0] data;
  } rec_t;

  typedef struct packed {
    rec_t        r;
    logic [31:0] cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wb_valid, wb_ready, wb_last;
  logic [31:0] wb_pc;
  logic [2:0] wb_warpId;
  logic [15:0] wb_tmask;
  logic [1:0] wb_beat;
  logic wb_regs_0_enable, wb_regs_1_enable, wb_regs_2_enable;
  logic [7:0] wb_regs_0_address, wb_regs_1_address, wb_regs_2_address;
  logic [127:0] wb_regs_0_data, wb_regs_1_data, wb_regs_2_data;
  logic trace_valid;
  logic [31:0] trace_pc;
  logic [2:0] trace_warpId;
  logic [15:0] trace_tmask;
  logic trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable;
  logic [7:0] trace_regs_0_address, trace_regs_1_address, trace_regs_2_address;
  logic [511:0] trace_regs_0_data, trace_regs_1_data, trace_regs_2_data;
  logic err_valid;
  logic [1:0] err_code;

  cyclotron_trace_packer dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_warpId(wb_warpId),
    .wb_tmask(wb_tmask), .wb_beat(wb_beat), .wb_last(wb_last),
    .wb_regs_0_enable(wb_regs_0_enable), .wb_regs_0_address(wb_regs_0_address), .wb_regs_0_data(wb_regs_0_data),
    .wb_regs_1_enable(wb_regs_1_enable), .wb_regs_1_address(wb_regs_1_address), .wb_regs_1_data(wb_regs_1_data),
    .wb_regs_2_enable(wb_regs_2_enable), .wb_regs_2_address(wb_regs_2_address), .wb_regs_2_data(wb_regs_2_data),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_warpId(trace_warpId), .trace_tmask(trace_tmask),
    .trace_regs_0_enable(trace_regs_0_enable), .trace_regs_0_address(trace_regs_0_address), .trace_regs_0_data(trace_regs_0_data),
    .trace_regs_1_enable(trace_regs_1_enable), .trace_regs_1_address(trace_regs_1_address), .trace_regs_1_data(trace_regs_1_data),
    .trace_regs_2_enable(trace_regs_2_enable), .trace_regs_2_address(trace_regs_2_address), .trace_regs_2_data(trace_regs_2_data),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   pushed = 0;
  exp_t expq[$];
  int   pulse_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc    = $urandom;
    r.warp  = 3'($urandom_range(0, 7));
    r.tmask = 16'($urandom);
    r.en    = 3'($urandom_range(0, 7));
    for (int k = 0; k < 3; k++) begin
      r.addr[k] = 8'($urandom);
      for (int g = 0; g < 16; g++) r.data[k][32*g +: 32] = $urandom;
    end
    return r;
  endfunction

  // Reference: a record emits its fields one cycle after its last handshake;
  // a disabled register reads as zero.
  logic [2:0][511:0] got_d;
  logic [2:0][7:0]   got_a;
  logic [2:0]        got_e;
  assign got_d = {trace_regs_2_data, trace_regs_1_data, trace_regs_0_data};
  assign got_a = {trace_regs_2_address, trace_regs_1_address, trace_regs_0_address};
  assign got_e = {trace_regs_2_enable, trace_regs_1_enable, trace_regs_0_enable};

  always @(negedge clock) begin
    if (trace_valid) begin
      exp_t e;
      pulses++;
      pulse_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_trace", 512'(trace_valid), 512'(0));
      end else begin
        e = expq.pop_front();
        chk("trace_cycle", 512'(cyc), 512'(e.cyc));
        chk("trace_pc", 512'(trace_pc), 512'(e.r.pc));
        chk("trace_warp", 512'(trace_warpId), 512'(e.r.warp));
        chk("trace_tmask", 512'(trace_tmask), 512'(e.r.tmask));
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("trace_en%0d", k), 512'(got_e[k]), 512'(e.r.en[k]));
          chk($sformatf("trace_addr%0d", k), 512'(got_a[k]), 512'(e.r.addr[k]));
          chk($sformatf("trace_data%0d", k), got_d[k], e.r.en[k] ? e.r.data[k] : 512'(0));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge one cycle after the handshake.
  task automatic drive_beat(input rec_t r, input int b, input logic last, input logic push);
    int w = 0;
    wb_valid = 1'b1;
    wb_pc = r.pc; wb_warpId = r.warp; wb_tmask = r.tmask;
    wb_beat = 2'(b); wb_last = last;
    {wb_regs_2_enable, wb_regs_1_enable, wb_regs_0_enable} = r.en;
    wb_regs_0_address = r.addr[0]; wb_regs_1_address = r.addr[1]; wb_regs_2_address = r.addr[2];
    wb_regs_0_data = r.data[0][b*128 +: 128];
    wb_regs_1_data = r.data[1][b*128 +: 128];
    wb_regs_2_data = r.data[2][b*128 +: 128];
    while (!wb_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!wb_ready) chk("ready_wait", 512'(wb_ready), 512'(1));
    if (push) begin
      expq.push_back('{r: r, cyc: 32'(cyc + 1)});
      pushed++;
    end
    @(negedge clock);
  endtask

  task automatic send_record(input rec_t r);
    for (int b = 0; b < 4; b++) drive_beat(r, b, b == 3, b == 3);
  endtask

  task automatic idle(input int n);
    wb_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 512'(trace_valid), 512'(0));
    chk({tag, "_rst_ready"}, 512'(wb_ready), 512'(0));
    chk({tag, "_rst_err"}, 512'({err_valid, err_code}), 512'(0));
    chk({tag, "_rst_pc"}, 512'({trace_pc, trace_warpId, trace_tmask}), 512'(0));
    chk({tag, "_rst_data"}, trace_regs_0_data | trace_regs_1_data | trace_regs_2_data, 512'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    rec_t r, r2;
    int   p0;
    wb_valid = 0; wb_pc = 0; wb_warpId = 0; wb_tmask = 0; wb_beat = 0; wb_last = 0;
    wb_regs_0_enable = 0; wb_regs_1_enable = 0; wb_regs_2_enable = 0;
    wb_regs_0_address = 0; wb_regs_1_address = 0; wb_regs_2_address = 0;
    wb_regs_0_data = 0; wb_regs_1_data = 0; wb_regs_2_data = 0;
    repeat (3) @(negedge clock);
    chk("reset_valid", 512'(trace_valid), 512'(0));
    chk("reset_ready", 512'(wb_ready), 512'(0));
    chk("reset_err", 512'({err_valid, err_code}), 512'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("ready_after_reset", 512'(wb_ready), 512'(1));

    // Directed single record: lane g of reg0 carries g, regs 1/2 disabled with garbage data.
    r = rand_rec();
    r.pc = 32'h8000_0010; r.warp = 3'd3; r.tmask = 16'hFFFF; r.en = 3'b001; r.addr[0] = 8'd5;
    for (int g = 0; g < 16; g++) r.data[0][32*g +: 32] = 32'(g);
    send_record(r);
    idle(3);
    chk("directed_pulses", 512'(pulses), 512'(1));
    chk("directed_err", 512'(err_valid), 512'(0));

    // Back-to-back records: 8 consecutive beats.
    p0 = pulses;
    r = rand_rec(); r2 = rand_rec();
    send_record(r);
    send_record(r2);
    idle(3);
    chk("b2b_pulses", 512'(pulses - p0), 512'(2));
    if (pulses - p0 == 2) chk("b2b_spacing", 512'(pulse_cyc[$] - pulse_cyc[$-1]), 512'(4));

    for (int i = 0; i < 20; i++) begin
      send_record(rand_rec());
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("random_err", 512'(err_valid), 512'(0));

    // Reset mid-record discards the partial record.
    r = rand_rec();
    drive_beat(r, 0, 1'b0, 1'b0);
    drive_beat(r, 1, 1'b0, 1'b0);
    wb_valid = 1'b0;
    do_reset("midrec");
    p0 = pulses;
    send_record(rand_rec());
    idle(4);
    chk("after_reset_pulses", 512'(pulses - p0), 512'(1));

    // Beat order 0, 2.
    p0 = pulses;
    r = rand_rec();
    drive_beat(r, 0, 1'b0, 1'b0);
    drive_beat(r, 2, 1'b0, 1'b0);
    chk("seq_err_valid", 512'(err_valid), 512'(1));
    chk("seq_err_code", 512'(err_code), 512'(1));
    chk("seq_ready", 512'(wb_ready), 512'(0));
    idle(5);
    chk("seq_ready_held", 512'(wb_ready), 512'(0));
    chk("seq_no_trace", 512'(pulses - p0), 512'(0));
    do_reset("seq");

    // Header mismatch on beat 1.
    p0 = pulses;
    r = rand_rec();
    drive_beat(r, 0, 1'b0, 1'b0);
    r2 = r; r2.pc = r.pc ^ 32'h4;
    drive_beat(r2, 1, 1'b0, 1'b0);
    chk("hdr_err_code", 512'({err_valid, err_code}), 512'({1'b1, 2'd2}));
    idle(5);
    chk("hdr_no_trace", 512'(pulses - p0), 512'(0));
    do_reset("hdr");

    // Timeout after beat 0.
    r = rand_rec();
    drive_beat(r, 0, 1'b0, 1'b0);
    idle(1023);
    chk("timeout_early", 512'(err_valid), 512'(0));
    idle(1);
    chk("timeout_err", 512'({err_valid, err_code}), 512'({1'b1, 2'd3}));
    do_reset("tmo");

    chk("queue_empty", 512'(expq.size()), 512'(0));
    chk("pulse_total", 512'(pulses), 512'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cyclotron_trace_packer.md
Name: cyclotron_trace_packer

Overview:
- Upstream neighbour of the Cyclotron difftest sink.
- The core's writeback path retires an instruction as NUM_LANES/WB_LANES lane-group beats.
- This block reassembles those beats into one full-warp trace record: pc, warpId, tmask and up to 3 register writes of NUM_LANES*ARCH_LEN data each.
- Each record is presented as a single-cycle trace_valid pulse on the trace_* bundle that the difftest sink consumes.
- It checks beat-protocol integrity and freezes on the first violation, so that difftest never sees a corrupt record.

Parameters:
ARCH_LEN, 32, data/pc width
NUM_WARPS, 8, warps per core; WARP_ID_BITS = $clog2(NUM_WARPS)
NUM_LANES, 16, lanes per warp
WB_LANES, 4, lanes per writeback beat; must divide NUM_LANES; NUM_BEATS = NUM_LANES/WB_LANES, BEAT_BITS = max(1, $clog2(NUM_BEATS))
REG_BITS, 8, register address width
TIMEOUT, 1024, maximum idle cycles allowed mid-record

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low (0 = reset)
wb_valid  in  1  beat valid
wb_ready  out  1  beat accepted when wb_valid && wb_ready
wb_pc  in  ARCH_LEN  instruction pc
wb_warpId  in  WARP_ID_BITS  warp id
wb_tmask  in  NUM_LANES  full-warp thread mask
wb_beat  in  BEAT_BITS  lane-group index
wb_last  in  1  final beat of instruction
wb_regs_k_enable  in  1  register k written (k = 0, 1, 2)
wb_regs_k_address  in  REG_BITS  register k address
wb_regs_k_data  in  WB_LANES*ARCH_LEN  register k lane-slice data
trace_valid  out  1  one-cycle record strobe
trace_pc  out  ARCH_LEN
trace_warpId  out  WARP_ID_BITS
trace_tmask  out  NUM_LANES
trace_regs_k_enable  out  1
trace_regs_k_address  out  REG_BITS
trace_regs_k_data  out  NUM_LANES*ARCH_LEN  lane g occupies bits [ARCH_LEN*g +: ARCH_LEN]
err_valid  out  1  sticky protocol error
err_code  out  2  0 none, 1 sequence, 2 header mismatch, 3 timeout

Behaviour:
- Reset (reset == 0, asynchronous): every output is 0, state = IDLE, accumulator and timeout counter cleared.
- Reset mid-record discards the partial record; no trace_valid is emitted for it.
- States:
  - IDLE: wb_ready = 1.
    - Accepted beat with wb_beat == 0: latch header (pc, warpId, tmask, enables, addresses), write slice 0, expected beat = 1.
    - If wb_last is also set on that beat, emit the record; otherwise go to ACCUM.
    - Accepted beat with wb_beat != 0: error, code 1.
  - ACCUM: wb_ready = 1.
    - Accepted beat must have wb_beat == expected beat; otherwise code 1.
    - pc, warpId, tmask, enables and addresses must equal the latched header; otherwise code 2.
    - Valid beat: write slice [WB_LANES*beat*ARCH_LEN +: WB_LANES*ARCH_LEN] for each enabled register, then increment expected beat.
    - wb_last set with beat != NUM_BEATS-1, or beat == NUM_BEATS-1 without wb_last: code 1.
    - Valid last beat: emit the record, go to IDLE.
  - ERROR: wb_ready = 0 permanently; err_valid = 1 and err_code is held; no further trace_valid. Only reset exits.
- Error precedence when several violations hit on one beat: code 1 over code 2. An erroring beat is consumed but not recorded.
- Emit:
  - On the cycle after the last-beat handshake, trace_valid = 1 for exactly one cycle and the trace_* fields are loaded from the accumulator.
  - The trace_* fields hold their values until the next emit.
  - Data of a disabled register is driven as 0.
  - The accumulator frees on the handshake cycle itself, so a new beat 0 may be accepted on the next cycle. With NUM_BEATS = 1 the sustained rate is one record per cycle.
- Timeout:
  - The counter clears on every accepted beat and on entry to ACCUM.
  - It increments on each ACCUM cycle with no accepted beat.
  - On reaching TIMEOUT it raises error code 3. The counter saturates and never wraps.
- No backpressure from the trace side: the downstream sink consumes every trace_valid.
- Data of tmask-inactive lanes passes through unmodified.

Decomposition:
- Shared package cyclotron_trace_pkg holds:
  - err_code_e {ERR_NONE, ERR_SEQ, ERR_HDR, ERR_TIMEOUT}
  - state_e {IDLE, ACCUM, ERROR}
  - the NUM_BEATS/BEAT_BITS derivation function
- One natural sub-module, cyclotron_trace_lane_accum: a 3-register lane-slice write-enable accumulator indexed by beat.
- The FSM, header compare, timeout counter and output register stay in the top module.

Test Plan:
- Default params: 4 beats, warpId 3, pc 0x80000010, tmask 0xFFFF, reg0 enable addr 5, lane g data = g, accepted on consecutive cycles. Required: trace_valid one cycle after beat 3, regs_0_data lane g = g, regs_1/2 enable 0 with data 0, err_valid 0.
- Two instructions back-to-back with no idle cycle (8 consecutive beats). Required: two trace_valid pulses exactly 4 cycles apart with correct pc per record.
- Beat order 0, 2. Required: err_valid = 1 and err_code = 1 one cycle after the beat-2 handshake, wb_ready = 0 thereafter, no trace_valid.
- Beat 1 with wb_pc differing from beat 0. Required: err_code = 2, no trace_valid.
- Beat 0 then idle for TIMEOUT = 1024 cycles. Required: err_code = 3 after exactly 1024 idle cycles.
- Reset asserted after beat 1, then a fresh 4-beat record. Required: all outputs 0 immediately on assertion; exactly one trace_valid, carrying only the new record.
